compress_ctrl_param: RTL

COMPRESS_CTRL_PARAM -- requirements
Module: compress_ctrl_param

---
 rtl/compress_ctrl_param.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/compress_ctrl_param.sv
// compress_ctrl_param: ingress beat controller that tags IPv4/TCP packets for compression.
// Define COMPRESS_UDP_EN to also accept UDP (protocol 0x11) headers.
module compress_ctrl_param #(
  parameter int          BURST_WIDTH = 256,
  parameter int          MAX_BEATS   = 64,
  parameter logic [15:0] MIN_LEN     = 16'd1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wrt_en,
  input  logic                           tvalid,
  input  logic                           tlast,
  input  logic                           full_infifo,
  input  logic                           empty_infifo,
  input  logic                           out_ready,
  input  logic [BURST_WIDTH-1:0]         data_in,
  output logic                           tready,
  output logic [2:0]                     state,
  output logic                           push_infifo,
  output logic                           pop_infifo,
  output logic                           flag_compression,
  output logic                           is_header,
  output logic                           overflow_err,
  output logic [$clog2(MAX_BEATS+1)-1:0] beat_count
);

  localparam int CW = $clog2(MAX_BEATS+1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_BEATS-1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STREAM_C = 3'd1,
    STREAM_B = 3'd2,
    DRAIN    = 3'd3,
    ERROR    = 3'd4
  } state_t;

  state_t          cur;
  state_t          nxt;
  logic            drain_seen;
  logic            flag_q;
  logic            ovf_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_now;
  logic            at_limit;
  logic            tready_raw;
  logic            accept;
  logic            push;
  logic [15:0]     eth_type;
  logic [15:0]     ip_len;
  logic [7:0]      proto;
  logic            proto_ok;
  logic            hdr_ok;
  logic [BURST_WIDTH-1:0] unused_data;

  // Only three header fields matter; the rest of the beat is payload.
  assign unused_data = data_in;
  assign eth_type    = data_in[111:96];
  assign ip_len      = {data_in[135:128], data_in[143:136]};
  assign proto       = data_in[191:184];

`ifdef COMPRESS_UDP_EN
  assign proto_ok = (proto == 8'h06) || (proto == 8'h11);
`else
  assign proto_ok = (proto == 8'h06);
`endif

  assign hdr_ok = (eth_type == 16'h0008) &&
                  (ip_len >= MIN_LEN) &&
                  proto_ok;

  always_comb begin
    tready_raw = 1'b0;
    unique case (1'b1)
      (cur == IDLE),
      (cur == STREAM_C),
      (cur == STREAM_B): tready_raw = wrt_en && !full_infifo;
      (cur == ERROR):    tready_raw = 1'b1;
      default:           tready_raw = 1'b0;
    endcase
  end

  assign tready      = tready_raw && !reset;
  assign accept      = tvalid && tready;
  assign push        = accept && (cur != ERROR);
  assign push_infifo = push;
  assign is_header   = push && (cur == IDLE);
  assign pop_infifo  = !reset && !empty_infifo && out_ready;

  // Count as seen before this beat; a header starts from zero.
  assign cnt_now  = (cur == IDLE) ? '0 : cnt;
  assign at_limit = (cnt_now == LIMIT);

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE: begin
        if (accept) begin
          if (tlast)         nxt = DRAIN;
          else if (at_limit) nxt = ERROR;
          else if (hdr_ok)   nxt = STREAM_C;
          else               nxt = STREAM_B;
        end
      end
      STREAM_C, STREAM_B: begin
        if (accept) begin
          if (tlast)         nxt = DRAIN;
          else if (at_limit) nxt = ERROR;
        end
      end
      ERROR: begin
        if (accept && tlast) nxt = DRAIN;
      end
      DRAIN: begin
        // First DRAIN cycle may still see the FIFO's stale empty flag.
        if (drain_seen && empty_infifo) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= IDLE;
      drain_seen <= 1'b0;
      flag_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      cur        <= nxt;
      drain_seen <= (cur == DRAIN) && (nxt == DRAIN);
      ovf_q      <= (nxt == ERROR) && (cur != ERROR);
      if (nxt == IDLE) begin
        flag_q <= 1'b0;
        cnt    <= '0;
      end else if (is_header) begin
        flag_q <= hdr_ok;
        cnt    <= CW'(1);
      end else if (push) begin
        cnt    <= cnt + CW'(1);
      end
    end
  end

  assign state            = cur;
  assign flag_compression = flag_q;
  assign overflow_err     = ovf_q;
  assign beat_count       = cnt;

endmodule
